// File: rtl/hdlc_frame_gen.sv
// hdlc_frame_gen - serial HDLC frame generator for driving a receiver's Rx input.
// One line bit per Clk cycle, every field LSB first. A frame is an opening flag,
// the zero-stuffed payload taken byte by byte over a valid/ready handshake, an
// optional CRC-16 FCS, then the closing flag. Frames can also end in an abort
// pattern, either on request or when the payload source underruns.
// Ports:
//   Clk, Rst           clock (one line bit per cycle), async active-low reset
//   Start              pulse: begin a frame (needs IDLE and enough idle ones)
//   DataIn/Valid/Last  payload byte stream; DataLast marks the final byte
//   DataReady          same-cycle pulse: DataIn/DataLast consumed
//   FcsEn, FcsCorrupt  sampled at Start: append FCS / invert FCS bit 0
//   AbortReq           pulse: abort the frame in progress
//   Tx                 serial line output (registered)
//   Busy               frame or abort in progress
//   FrameDone/Aborted  one-cycle pulse with the last closing-flag / abort bit
//   ByteCount          payload bytes consumed in the current/last frame (saturating)
module hdlc_frame_gen #(
   parameter int          IDLE_MIN = 8,
   parameter logic [15:0] FCS_INIT = 16'h0000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic [7:0] DataIn,
   input  logic       DataValid,
   input  logic       DataLast,
   output logic       DataReady,
   input  logic       FcsEn,
   input  logic       FcsCorrupt,
   input  logic       AbortReq,
   output logic       Tx,
   output logic       Busy,
   output logic       FrameDone,
   output logic       Aborted,
   output logic [7:0] ByteCount
);

   localparam int IW = $clog2(IDLE_MIN + 2);
   localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MIN);
   localparam logic [7:0] FLAG = 8'h7E;   // 0,1,1,1,1,1,1,0 on the line
   localparam logic [7:0] ABRT = 8'hFE;   // 0,1,1,1,1,1,1,1 on the line

   typedef enum logic [2:0] {S_IDLE, S_OPEN, S_DATA, S_FCS, S_CLOSE, S_ABORT} state_t;

   state_t         state;
   logic [3:0]     bitCnt;     // index of the field bit currently on Tx
   logic [2:0]     onesCnt;    // consecutive ones on Tx inside DATA/FCS
   logic [15:0]    sh;         // remaining bits of the byte or FCS being sent
   logic [15:0]    crc;
   logic           lastByte;
   logic           fcsEnR;
   logic           fcsCorR;
   logic [IW-1:0]  idleCnt;

   logic           abortOk;
   logic           stuffNeed;
   logic           boundary;
   logic           goAbort;
   logic           startOk;
   logic [2:0]     nxtIdx;
   logic [15:0]    fcsVal;

   function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h8005 : 16'h0000);
   endfunction

   assign Busy      = (state != S_IDLE);
   assign abortOk   = AbortReq && (state == S_OPEN || state == S_DATA || state == S_FCS);
   // Five ones already on the line: the next bit is a stuffed 0 and the shifter stalls.
   assign stuffNeed = (state == S_DATA || state == S_FCS) && (onesCnt == 3'd5);
   // Byte boundary: the next edge wants a fresh payload byte.
   assign boundary  = (state == S_OPEN && bitCnt[2:0] == 3'd7) ||
                      (state == S_DATA && bitCnt[2:0] == 3'd7 && !stuffNeed && !lastByte);
   assign DataReady = boundary && DataValid && !abortOk;
   assign goAbort   = abortOk || (boundary && !DataValid);
   assign startOk   = (state == S_IDLE) && Start && (idleCnt == IDLE_SAT);
   assign nxtIdx    = bitCnt[2:0] + 3'd1;
   assign fcsVal    = crc ^ {15'd0, fcsCorR};

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= S_IDLE;
         Tx        <= 1'b1;
         FrameDone <= 1'b0;
         Aborted   <= 1'b0;
         ByteCount <= 8'd0;
         bitCnt    <= 4'd0;
         onesCnt   <= 3'd0;
         sh        <= 16'd0;
         crc       <= FCS_INIT;
         lastByte  <= 1'b0;
         fcsEnR    <= 1'b0;
         fcsCorR   <= 1'b0;
         idleCnt   <= IDLE_SAT;
      end else begin
         FrameDone <= 1'b0;
         Aborted   <= 1'b0;
         if (goAbort) begin
            // Any pending stuffed 0 is dropped; the abort pattern starts now.
            state   <= S_ABORT;
            Tx      <= 1'b0;
            bitCnt  <= 4'd0;
            onesCnt <= 3'd0;
         end else if (DataReady) begin
            state    <= S_DATA;
            Tx       <= DataIn[0];
            sh       <= {9'd0, DataIn[7:1]};
            crc      <= crcStep(crc, DataIn[0]);
            onesCnt  <= DataIn[0] ? onesCnt + 3'd1 : 3'd0;
            bitCnt   <= 4'd0;
            lastByte <= DataLast;
            if (ByteCount != 8'hFF) ByteCount <= ByteCount + 8'd1;
         end else if (stuffNeed) begin
            Tx      <= 1'b0;
            onesCnt <= 3'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  Tx <= 1'b1;
                  if (idleCnt != IDLE_SAT) idleCnt <= idleCnt + IW'(1);
                  if (startOk) begin
                     state     <= S_OPEN;
                     Tx        <= FLAG[0];
                     bitCnt    <= 4'd0;
                     onesCnt   <= 3'd0;
                     crc       <= FCS_INIT;
                     ByteCount <= 8'd0;
                     fcsEnR    <= FcsEn;
                     fcsCorR   <= FcsCorrupt;
                  end
               end
               S_OPEN: begin
                  bitCnt <= bitCnt + 4'd1;
                  Tx     <= FLAG[nxtIdx];
               end
               S_DATA: begin
                  if (bitCnt[2:0] != 3'd7) begin
                     Tx      <= sh[0];
                     sh      <= {1'b0, sh[15:1]};
                     crc     <= crcStep(crc, sh[0]);
                     onesCnt <= sh[0] ? onesCnt + 3'd1 : 3'd0;
                     bitCnt  <= bitCnt + 4'd1;
                  end else if (fcsEnR) begin
                     state   <= S_FCS;
                     Tx      <= fcsVal[0];
                     sh      <= {1'b0, fcsVal[15:1]};
                     onesCnt <= {2'b00, fcsVal[0]};
                     bitCnt  <= 4'd0;
                  end else begin
                     state   <= S_CLOSE;
                     Tx      <= FLAG[0];
                     onesCnt <= 3'd0;
                     bitCnt  <= 4'd0;
                  end
               end
               S_FCS: begin
                  if (bitCnt != 4'd15) begin
                     Tx      <= sh[0];
                     sh      <= {1'b0, sh[15:1]};
                     onesCnt <= sh[0] ? onesCnt + 3'd1 : 3'd0;
                     bitCnt  <= bitCnt + 4'd1;
                  end else begin
                     state   <= S_CLOSE;
                     Tx      <= FLAG[0];
                     onesCnt <= 3'd0;
                     bitCnt  <= 4'd0;
                  end
               end
               S_CLOSE, S_ABORT: begin
                  if (bitCnt[2:0] == 3'd7) begin
                     state   <= S_IDLE;
                     Tx      <= 1'b1;
                     idleCnt <= '0;
                  end else begin
                     bitCnt <= bitCnt + 4'd1;
                     Tx     <= (state == S_CLOSE) ? FLAG[nxtIdx] : ABRT[nxtIdx];
                     if (bitCnt[2:0] == 3'd6) begin
                        FrameDone <= (state == S_CLOSE);
                        Aborted   <= (state == S_ABORT);
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hdlc_frame_gen.sv
// Bench for hdlc_frame_gen: a table of frame vectors is run through a
// bit-level line model; expected line bits are queued at Start and popped
// one per cycle as the DUT shifts them out. Hand sequences cover idle-gap
// Start rejection, Start while busy and reset in the middle of a frame.
module tb_hdlc_frame_gen;
   localparam int IDLE_MIN = 8;

   logic       Clk = 1'b0, Rst = 1'b0, Start = 1'b0;
   logic [7:0] DataIn = 8'h00;
   logic       DataValid = 1'b0, DataLast = 1'b0, FcsEn = 1'b0, FcsCorrupt = 1'b0, AbortReq = 1'b0;
   logic       DataReady, Tx, Busy, FrameDone, Aborted;
   logic [7:0] ByteCount;

   hdlc_frame_gen #(.IDLE_MIN(IDLE_MIN), .FCS_INIT(16'h0000)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .DataIn(DataIn), .DataValid(DataValid),
      .DataLast(DataLast), .DataReady(DataReady), .FcsEn(FcsEn), .FcsCorrupt(FcsCorrupt),
      .AbortReq(AbortReq), .Tx(Tx), .Busy(Busy), .FrameDone(FrameDone), .Aborted(Aborted),
      .ByteCount(ByteCount));

   always #5 Clk = ~Clk;

   typedef struct { logic tx; logic done; logic abt; } exp_t;
   typedef struct {
      int              n;
      logic [3:0][7:0] b;
      logic            gen;
      logic            fcs;
      logic            cor;
      logic            under;
      int              abortAt;
      int              expCnt;
      logic            expDone;
   } vec_t;

   exp_t       expQ[$];
   logic       lineQ[$];
   logic       msgQ[$];
   int         onesM;
   vec_t       vecs[14];
   logic [7:0] curBytes[256];
   int         curN = 0, curAbort = -1, fed = 0, lineIdx = 0, spurIdx = -1, sinceEnd = 1000;
   logic       curUnder = 1'b0;
   int         nChk = 0, nPass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nChk++;
      if (act == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d (line bit %0d, t=%0t)", nm, act, exp, lineIdx, $time);
   endtask

   // Append one DATA/FCS bit with zero insertion after five consecutive ones.
   task automatic addBit(input logic b);
      lineQ.push_back(b);
      onesM = b ? onesM + 1 : 0;
      if (onesM == 5) begin
         lineQ.push_back(1'b0);
         onesM = 0;
      end
   endtask

   // CRC as the remainder of M(x)*x^16 divided by x^16+x^15+x^2+1, first line bit = highest power.
   function automatic logic [15:0] polyRem();
      logic        m[$];
      logic [16:0] g;
      logic [15:0] r;
      g = 17'h18005;
      m = msgQ;
      for (int k = 0; k < 16; k++) m.push_back(1'b0);
      for (int i = 0; i + 16 < m.size(); i++)
         if (m[i]) for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
      for (int k = 0; k < 16; k++) r[15-k] = m[m.size()-16+k];
      return r;
   endfunction

   task automatic buildExp(input logic fcs, input logic cor);
      logic [7:0]  flag, abrt;
      logic [15:0] f;
      logic        endDone;
      flag = 8'h7E;
      abrt = 8'hFE;
      lineQ.delete();
      msgQ.delete();
      for (int k = 0; k < 8; k++) lineQ.push_back(flag[k]);
      onesM = 0;
      for (int i = 0; i < curN; i++)
         for (int k = 0; k < 8; k++) begin
            msgQ.push_back(curBytes[i][k]);
            addBit(curBytes[i][k]);
         end
      endDone = 1'b0;
      if (!curUnder) begin
         if (fcs) begin
            f = polyRem();
            f[0] = f[0] ^ cor;
            onesM = 0;
            for (int k = 0; k < 16; k++) addBit(f[k]);
         end
         for (int k = 0; k < 8; k++) lineQ.push_back(flag[k]);
         endDone = 1'b1;
      end
      if (curAbort >= 0) begin
         while (lineQ.size() > curAbort + 1) void'(lineQ.pop_back());
         endDone = 1'b0;
      end
      if (!endDone) for (int k = 0; k < 8; k++) lineQ.push_back(abrt[k]);
      for (int k = 0; k < lineQ.size(); k++)
         expQ.push_back('{lineQ[k], endDone && (k == lineQ.size()-1), !endDone && (k == lineQ.size()-1)});
   endtask

   task automatic cycle(input logic st);
      exp_t e;
      logic inFrame;
      @(posedge Clk);
      #1;
      inFrame   = (expQ.size() > 0);
      Start     = st || (inFrame && lineIdx == spurIdx);
      AbortReq  = inFrame && (lineIdx == curAbort);
      DataValid = inFrame && (fed < curN);
      DataIn    = (fed < curN) ? curBytes[fed] : 8'h00;
      DataLast  = !curUnder && (fed == curN - 1);
      @(negedge Clk);
      if (inFrame) begin
         e = expQ.pop_front();
         chk("Tx", Tx, e.tx);
         chk("Busy", Busy, 1);
         chk("FrameDone", FrameDone, e.done);
         chk("Aborted", Aborted, e.abt);
         lineIdx++;
         if (expQ.size() == 0) sinceEnd = 0;
      end else begin
         chk("idle Tx", Tx, 1);
         chk("idle Busy", Busy, 0);
         chk("idle DataReady", DataReady, 0);
         if (sinceEnd < 1000) sinceEnd++;
      end
      if (DataReady) fed++;
   endtask

   task automatic setupVec(input int i);
      curN = vecs[i].n;
      for (int k = 0; k < curN; k++)
         curBytes[k] = vecs[i].gen ? 8'(k * 37 + 5) : vecs[i].b[k];
      curUnder   = vecs[i].under;
      curAbort   = vecs[i].abortAt;
      FcsEn      = vecs[i].fcs;
      FcsCorrupt = vecs[i].cor;
      fed        = 0;
   endtask

   task automatic startFrame(input logic fcs, input logic cor);
      for (int w = 0; w < 20 && sinceEnd < IDLE_MIN; w++) cycle(1'b0);
      cycle(1'b1);
      lineIdx = 0;
      buildExp(fcs, cor);
   endtask

   task automatic runFrame(input int i);
      setupVec(i);
      startFrame(vecs[i].fcs, vecs[i].cor);
      for (int w = 0; w < 4000 && expQ.size() > 0; w++) cycle(1'b0);
      if (expQ.size() > 0) begin
         nChk++;
         $display("FAIL vec%0d timeout: %0d line bits still pending", i, expQ.size());
         expQ.delete();
         sinceEnd = 0;
      end
      chk($sformatf("vec%0d ByteCount", i), ByteCount, vecs[i].expCnt);
      chk($sformatf("vec%0d consumed", i), fed, vecs[i].expCnt);
   endtask

   initial begin
      //          n    bytes         gen fcs cor und abortAt cnt done
      vecs[0]  = '{1,   32'h00000001, 0, 0, 0, 0, -1,  1,   1};
      vecs[1]  = '{1,   32'h000000FF, 0, 0, 0, 0, -1,  1,   1};
      vecs[2]  = '{2,   32'h00003412, 0, 1, 0, 0, -1,  2,   1};
      vecs[3]  = '{2,   32'h00003412, 0, 1, 1, 0, -1,  2,   1};
      vecs[4]  = '{3,   32'h00563412, 0, 0, 0, 0, 19,  2,   0};
      vecs[5]  = '{2,   32'h00003412, 0, 0, 0, 0, 15,  1,   0};
      vecs[6]  = '{2,   32'h00003412, 0, 1, 0, 0, 30,  2,   0};
      vecs[7]  = '{2,   32'h00003412, 0, 0, 0, 0, 3,   0,   0};
      vecs[8]  = '{2,   32'h000055AA, 0, 0, 0, 1, -1,  2,   0};
      vecs[9]  = '{0,   32'h00000000, 0, 0, 0, 1, -1,  0,   0};
      vecs[10] = '{130, 32'h00000000, 1, 1, 0, 0, -1,  130, 1};
      vecs[11] = '{2,   32'h0000F83E, 0, 0, 0, 0, -1,  2,   1};
      vecs[12] = '{2,   32'h0000FFFF, 0, 1, 0, 0, -1,  2,   1};
      vecs[13] = '{2,   32'h00003412, 0, 0, 0, 0, 7,   0,   0};

      // Reset state
      #12;
      chk("reset Tx", Tx, 1);
      chk("reset Busy", Busy, 0);
      chk("reset DataReady", DataReady, 0);
      chk("reset FrameDone", FrameDone, 0);
      chk("reset Aborted", Aborted, 0);
      chk("reset ByteCount", ByteCount, 0);
      #5 Rst = 1'b1;

      // Start straight out of reset (idle count starts at IDLE_MIN)
      runFrame(0);

      // Starts at idle counts 2 and 7 are ignored; the next one at 8 is taken.
      // A Start during the following frame must not disturb it.
      repeat (2) cycle(1'b0);
      cycle(1'b1);
      repeat (4) cycle(1'b0);
      cycle(1'b1);
      spurIdx = 5;
      runFrame(1);
      spurIdx = -1;

      for (int i = 2; i < 14; i++) runFrame(i);

      // Reset in the middle of DATA: Tx returns to 1 without a clock edge
      curN = 4;
      for (int k = 0; k < 4; k++) curBytes[k] = 8'h00;
      curUnder = 1'b0;
      curAbort = -1;
      FcsEn = 1'b0;
      FcsCorrupt = 1'b0;
      fed = 0;
      startFrame(1'b0, 1'b0);
      repeat (12) cycle(1'b0);
      @(posedge Clk);
      #2 Rst = 1'b0;
      #1;
      chk("midreset Tx", Tx, 1);
      chk("midreset Busy", Busy, 0);
      chk("midreset ByteCount", ByteCount, 0);
      expQ.delete();
      sinceEnd = 1000;
      #4 Rst = 1'b1;
      repeat (3) cycle(1'b0);

      // Idle count is back at IDLE_MIN after reset, so a Start is taken at once
      runFrame(0);
      repeat (3) cycle(1'b0);

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
